// File: rtl/ps2_keys_pkg.sv
// Shared scan-code constants, decoder state encoding and held-key indices
// for the PS/2 movement-key receiver.
package ps2_keys_pkg;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    localparam logic [7:0] CODE_W     = 8'h1D;
    localparam logic [7:0] CODE_A     = 8'h1C;
    localparam logic [7:0] CODE_S     = 8'h1B;
    localparam logic [7:0] CODE_D     = 8'h23;
    localparam logic [7:0] CODE_UP    = 8'h75;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_DOWN  = 8'h72;
    localparam logic [7:0] CODE_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } dec_state_t;

    localparam int KEY_W     = 0;
    localparam int KEY_A     = 1;
    localparam int KEY_S     = 2;
    localparam int KEY_D     = 3;
    localparam int KEY_UP    = 4;
    localparam int KEY_LEFT  = 5;
    localparam int KEY_DOWN  = 6;
    localparam int KEY_RIGHT = 7;

    // One-hot mask into the held-key vector; all zeros for unmapped codes.
    function automatic logic [7:0] key_mask(input logic ext, input logic [7:0] code);
        logic [7:0] mask;
        mask = '0;
        if (ext) begin
            case (code)
                CODE_UP:    mask[KEY_UP]    = 1'b1;
                CODE_LEFT:  mask[KEY_LEFT]  = 1'b1;
                CODE_DOWN:  mask[KEY_DOWN]  = 1'b1;
                CODE_RIGHT: mask[KEY_RIGHT] = 1'b1;
                default:    mask = '0;
            endcase
        end else begin
            case (code)
                CODE_W:  mask[KEY_W] = 1'b1;
                CODE_A:  mask[KEY_A] = 1'b1;
                CODE_S:  mask[KEY_S] = 1'b1;
                CODE_D:  mask[KEY_D] = 1'b1;
                default: mask = '0;
            endcase
        end
        return mask;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receive path: pin synchronisers, falling-edge detect, 11-bit frame
// assembly with start/parity/stop checks and a partial-frame timeout.
module ps2_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       clk_sync;
    logic [1:0]       dat_sync;
    logic             clk_prev;
    logic             fall;
    logic [3:0]       bit_cnt;
    logic [9:0]       shift;
    logic [CNT_W-1:0] idle_cnt;
    logic             frame_ok;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync <= '0;
            dat_sync <= '0;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall = clk_prev & ~clk_sync[1];

    // shift[0] holds the start bit once ten bits are in; the live data bit is the stop bit.
    assign frame_ok = ~shift[0] & dat_sync[1] & (^shift[9:1]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt     <= '0;
            shift       <= '0;
            idle_cnt    <= '0;
            scan_code   <= 8'h00;
            scan_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            scan_valid  <= 1'b0;
            frame_error <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (frame_ok) begin
                        scan_code  <= shift[8:1];
                        scan_valid <= 1'b1;
                    end else begin
                        frame_error <= 1'b1;
                    end
                end else begin
                    shift   <= {dat_sync[1], shift[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (idle_cnt == TIMEOUT_LAST) begin
                    frame_error <= 1'b1;
                    bit_cnt     <= '0;
                    idle_cnt    <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_movement_keys.sv
// Decodes PS/2 make/break sequences for arrows and W/A/S/D into one held
// level per movement direction for the player update stage.
module ps2_movement_keys
    import ps2_keys_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       turn_right,
    output logic       turn_left,
    output logic       move_forward,
    output logic       move_backward,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_error
);

    dec_state_t state;
    dec_state_t next_state;
    logic [7:0] held;
    logic [7:0] next_held;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clock       (clock),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_dat     (ps2_dat),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .frame_error (frame_error)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            held  <= '0;
        end else begin
            state <= next_state;
            held  <= next_held;
        end
    end

    // A dropped frame abandons any pending prefix but keeps held keys as they were.
    always_comb begin
        next_state = state;
        next_held  = held;
        if (frame_error) begin
            next_state = IDLE;
        end else if (scan_valid) begin
            case (state)
                IDLE: begin
                    if (scan_code == PREFIX_EXT) begin
                        next_state = EXT;
                    end else if (scan_code == PREFIX_BRK) begin
                        next_state = BRK;
                    end else begin
                        next_held = held | key_mask(1'b0, scan_code);
                    end
                end
                EXT: begin
                    if (scan_code == PREFIX_BRK) begin
                        next_state = EXT_BRK;
                    end else begin
                        next_held  = held | key_mask(1'b1, scan_code);
                        next_state = IDLE;
                    end
                end
                BRK: begin
                    next_held  = held & ~key_mask(1'b0, scan_code);
                    next_state = IDLE;
                end
                EXT_BRK: begin
                    next_held  = held & ~key_mask(1'b1, scan_code);
                    next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    assign turn_right    = held[KEY_RIGHT] | held[KEY_D];
    assign turn_left     = held[KEY_LEFT]  | held[KEY_A];
    assign move_forward  = held[KEY_UP]    | held[KEY_W];
    assign move_backward = held[KEY_DOWN]  | held[KEY_S];

endmodule

// File: doc/ps2_movement_keys.md
# ps2_movement_keys

Receives PS/2 keyboard frames, decodes make/break scan codes for the arrow keys and W/A/S/D, and holds one level signal per movement direction. It sits directly upstream of the player update stage and drives its turn_right, turn_left, move_forward and move_backward inputs. Receive only; no host-to-device traffic.

## Interface
- TIMEOUT_CYCLES, 50000: idle clock cycles after a ps2_clk falling edge before a partial frame is discarded (1 ms at 50 MHz).
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low; clears all state.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_dat  in  1  raw PS/2 data pin, asynchronous.
- turn_right  out  1  high while Right-arrow or D is held.
- turn_left  out  1  high while Left-arrow or A is held.
- move_forward  out  1  high while Up-arrow or W is held.
- move_backward  out  1  high while Down-arrow or S is held.
- scan_code  out  8  last correctly received byte, for debug.
- scan_valid  out  1  one-cycle pulse when scan_code updates.
- frame_error  out  1  one-cycle pulse when a frame is dropped for bad start, parity, stop or timeout.

## Operation
- Reset values: all outputs 0, scan_code 8'h00, receiver and decoder idle, key-held registers cleared.
- Synchroniser: ps2_clk and ps2_dat each pass through 2 flops. A falling edge is previous synced clock = 1 and current = 0.
- Frame receiver: on each falling edge, shift in ps2_dat. A frame is 11 bits: start 0, 8 data bits LSB first, odd parity, stop 1. The bit counter runs 0..10.
  - At bit 10 (stop bit), check start == 0, stop == 1, and odd parity over data+parity.
  - Pass: pulse scan_valid and load scan_code. Fail: pulse frame_error and drop the byte. In both cases the bit counter returns to 0.
- Timeout counter: clears on every falling edge and counts while the bit counter is nonzero. On reaching TIMEOUT_CYCLES, pulse frame_error, clear the bit counter and drop the partial byte.
- Decoder FSM, advanced only by valid bytes:
  - IDLE: E0 → EXT; F0 → BRK; anything else is a base make.
  - EXT: F0 → EXT_BRK; anything else is an extended make, then IDLE.
  - BRK: base break, then IDLE.
  - EXT_BRK: extended break, then IDLE.
  - frame_error forces IDLE and leaves the key-held registers unchanged.
- Key map:
  - Base: 1D=W, 1C=A, 1B=S, 23=D.
  - Extended: 75=Up, 6B=Left, 72=Down, 74=Right.
  - A make sets the matching held bit; a break clears it.
  - Unmapped codes, including E1 and Pause sequences, change nothing except returning the FSM to IDLE.
  - Typematic repeat makes re-set an already-set bit, with no visible change.
- Output combine: each direction output is the OR of its arrow bit and its letter bit. Simultaneous keys all show high; the downstream stage treats non-one-hot as no movement, and this block applies no priority.
- Reset asserted mid-frame: everything clears immediately. A frame still in progress when reset releases is received from its next bit; it fails the start/stop check or times out, and produces frame_error.

## Timing
- Pin edge to internal falling-edge strobe: 3 clock edges, with ±1 for async sampling.
- Stop-bit falling edge to scan_valid/frame_error pulse: 1 cycle after the strobe.
- Valid byte to direction output change: exactly 1 cycle after scan_valid.
- Total latency, final ps2_clk falling edge at the pin to output change: 5 clocks ±1.
- Minimum PS/2 bit period is 60 µs (3000 clocks), so no back-pressure is needed and all bytes are processed in order.

## Structure
- Package ps2_keys_pkg holds:
  - scan-code constants: PREFIX_EXT=8'hE0, PREFIX_BRK=8'hF0, and the eight key codes;
  - decoder state encoding: IDLE, EXT, BRK, EXT_BRK;
  - index constants for the 8-bit held-key vector.
- Sub-module ps2_rx holds the synchronisers, edge detect, shift register, parity check and timeout. It outputs scan_code, scan_valid and frame_error.
- The top level holds the decoder FSM, the held-key register and the output ORs.

## Test plan
- Send frame 8'h1D (W) → scan_valid pulses once with scan_code 1D. move_forward rises 5±1 clocks after the final ps2_clk fall; other outputs stay 0.
- Send E0 75, then E0 F0 75 → move_forward high after the first pair, low after the break. The FSM passes EXT and EXT_BRK and ends in IDLE.
- Send 1C, then E0 6B, then F0 1C → turn_left stays high until the Left-arrow break is also sent (E0 F0 6B), then goes low.
- Send frame 8'h23 with even parity → frame_error pulses, no scan_valid, turn_right stays 0. The next valid 23 sets turn_right.
- Send 5 bits, then idle for TIMEOUT_CYCLES → frame_error pulses at count 50000. A following complete frame 1B sets move_backward.
- Hold W and Right together (1D, E0 74), then pulse reset low mid-frame → all outputs 0 within the same cycle, and the decoder returns to IDLE.
